// File: rtl/button_conditioner.sv
// Five-channel push-button front end: two-flop synchroniser, per-channel
// stability counter, registered debounced level and single-cycle press pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 360000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press
);

  localparam int N_BTN = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    QUALIFY = 1'b1
  } chan_state_t;

  logic [N_BTN-1:0]            sync1;
  logic [N_BTN-1:0]            sync2;
  logic [N_BTN-1:0]            stable;
  logic [N_BTN-1:0]            press;
  logic [N_BTN-1:0][CNT_W-1:0] cnt;

  logic [N_BTN-1:0]            stable_nxt;
  logic [N_BTN-1:0]            press_nxt;
  logic [N_BTN-1:0][CNT_W-1:0] cnt_nxt;
  logic [N_BTN-1:0]            accept;
  chan_state_t                 state [N_BTN];

  // Counter only ever counts up while qualifying; any return to agreement
  // discards the partial count, so it can never pass CNT_LAST or wrap.
  function automatic logic [CNT_W-1:0] cnt_advance(
    input logic [CNT_W-1:0] c,
    input logic             qualifying,
    input logic             done
  );
    if (qualifying && !done) begin
      return c + CNT_W'(1);
    end
    return '0;
  endfunction

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      cnt    <= '0;
      press  <= '0;
    end else begin
      sync1  <= btn_raw;
      sync2  <= sync1;
      stable <= stable_nxt;
      cnt    <= cnt_nxt;
      press  <= press_nxt;
    end
  end

  // Channel state is implied by whether the synchronised input disagrees
  // with the accepted level; no separate encoding is stored.
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = '0;
    accept     = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state[i]      = (sync2[i] != stable[i]) ? QUALIFY : IDLE;
      accept[i]     = (state[i] == QUALIFY) && (cnt[i] == CNT_LAST);
      stable_nxt[i] = accept[i] ? sync2[i] : stable[i];
      cnt_nxt[i]    = cnt_advance(cnt[i], state[i] == QUALIFY, accept[i]);
    end
  end

  // Pulse only when the accepted transition is towards pressed.
  always_comb begin
    press_nxt = '0;
    for (int i = 0; i < N_BTN; i++) begin
      press_nxt[i] = accept[i] & sync2[i];
    end
  end

  assign btn_level = stable;
  assign btn_press = press;

endmodule
